rob_param: RTL and testbench
============================

Name: rob_param

Overview:
- Parametrised reorder buffer. Successor to the single-result ROB, now with configurable depth and widths.
- Adds two writeback channels (ALU, LSB), two combinational operand-lookup ports for the RS, and store-commit signalling to the LSB.
- Adds in-order single-entry commit with branch-misprediction flush and a redirect PC.
- Sits between decode/issue, the RS/LSB, the register file and the fetch unit (ICache/PC).

Parameters:
DEPTH, 16, number of entries; power of two, >=2
IDX_W, 4, log2(DEPTH); width of ROB tags
XLEN, 32, data and PC width
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
rdy  in  1  global enable; 0 = stall
issue_valid  in  1  allocate entry this cycle
issue_type  in  2  0=reg-write, 1=branch, 2=store, 3=reg-write-done (e.g. LUI, complete at issue)
issue_rd  in  REG_W  destination register (types 0/3)
issue_pc  in  XLEN  instruction PC
issue_pred_taken  in  1  predictor decision (type 1)
issue_value  in  XLEN  result for type 3
issue_tag  out  IDX_W  tag the next allocation will receive (= tail)
full  out  1  count==DEPTH
count  out  IDX_W+1  occupied entries
wb0_valid  in  1  ALU writeback
wb0_tag  in  IDX_W  target entry
wb0_value  in  XLEN  result / link value
wb0_taken  in  1  actual branch outcome
wb0_target  in  XLEN  actual branch target
wb1_valid  in  1  LSB writeback (loads, store-address-ready)
wb1_tag  in  IDX_W  target entry
wb1_value  in  XLEN  load data
q0_tag, q1_tag  in  IDX_W  RS operand lookup tags
q0_ready, q1_ready  out  1  entry holds result
q0_value, q1_value  out  XLEN  entry result
commit_valid  out  1  one-cycle pulse: register write
commit_rd  out  REG_W  register written
commit_value  out  XLEN  value written
commit_tag  out  IDX_W  committing tag (RF clears dependency if equal)
store_commit_valid  out  1  one-cycle pulse: LSB may perform store
store_commit_tag  out  IDX_W  store's tag
flush  out  1  one-cycle pulse: mispredict, squash everything
flush_pc  out  XLEN  redirect PC

Behaviour:
- Reset (rst=0 at posedge): head=tail=count=0; all busy/ready bits 0. Registered outputs all 0: commit_valid, commit_rd, commit_value, commit_tag, store_commit_valid, store_commit_tag, flush, flush_pc.
- rdy=0: no state change. commit_valid, store_commit_valid and flush are driven 0 next cycle; other registered outputs hold.
- Entry fields: busy, ready, type, rd, pc, pred_taken, value, taken, target.
- Allocate: issue_valid && !full && !flush → entry[tail] gets busy=1, ready=(type==3), fields loaded; tail++ (wraps modulo DEPTH). full uses the registered count, so a commit in the same cycle does not admit an allocation when full. issue_valid while full is ignored; upstream must hold it.
- Writeback:
  - wbN_valid && entry busy → ready=1, value captured; wb0 also captures taken and target.
  - Writeback to a non-busy entry is ignored.
  - Both channels to the same tag in one cycle: wb0 wins.
  - wb1 to a store entry marks it ready; value is unused.
- Lookup ports: combinational. qN_ready = busy&&ready of the entry; qN_value = its value. No same-cycle writeback bypass; the RS snoops the CDB itself.
- Commit:
  - Condition: count>0 && entry[head].ready, evaluated on registered state, so a writeback arriving this cycle commits next cycle at the earliest.
  - At most one commit per cycle. Head entry busy←0; head++ with wrap.
  - Type 0/3: commit_valid=1 next cycle with rd, value, tag. rd==0 still pulses; the RF ignores x0.
  - Type 2: store_commit_valid=1 next cycle with tag.
  - Type 1: commit_valid=1 only if rd!=0 (JAL/JALR link); value=link.
  - If taken!=pred_taken: flush=1 next cycle; flush_pc = taken ? target : pc+4. At the same edge all busy bits clear and head=tail=count=0.
- Flush cycle (flush=1): issue_valid and wb inputs ignored, no commit. Allocation resumes the cycle after, with tag 0.
- Same-cycle allocate+commit: count unchanged; tail and head both advance.
- Count: +1 on alloc, -1 on commit, net 0 when both.
- Widths: pc+4 is modulo 2^XLEN; pointer wrap by IDX_W-bit truncation.

Test Plan:
- Reset then 3 type-0 issues (rd=1,2,3) → issue_tag 0,1,2, count=3. wb0 tags 2,0,1 with values 0x30,0x10,0x20 → commits in order rd1=0x10, rd2=0x20, rd3=0x30 on consecutive cycles.
- Fill 16 entries → full=1, 17th issue ignored. Make head ready and issue in the same cycle → allocation refused that cycle, accepted the next with issue_tag=0 (wrap).
- Branch at pc=0x100, pred_taken=0, wb0 taken=1 target=0x200, three younger entries busy → flush=1 one cycle, flush_pc=0x200, count=0, next issue_tag=0, younger entries never commit.
- Branch pred_taken=1, actual taken=0, pc=0xFFFFFFFC → flush_pc=0x00000000 (wrap). Correct prediction → no flush, normal commit.
- Store entry tag 5: wb1 tag 5 → store_commit_valid pulse with tag 5, no commit_valid. wb0 and wb1 to tag 6 in the same cycle with 0xA/0xB → q0_tag=6 reads ready=1, value=0xA.
- rdy=0 for 3 cycles with a ready head → no commit, count held; commit occurs the first cycle after rdy=1. Reset asserted mid-stream → all outputs 0 and count 0 next cycle.

Source files
------------

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocation, two writeback channels,
// two combinational operand lookups, single-entry in-order commit with mispredict flush.
module rob_param #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4,
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [1:0]       issue_type,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [XLEN-1:0]  issue_pc,
  input  logic             issue_pred_taken,
  input  logic [XLEN-1:0]  issue_value,
  output logic [IDX_W-1:0] issue_tag,
  output logic             full,
  output logic [IDX_W:0]   count,
  input  logic             wb0_valid,
  input  logic [IDX_W-1:0] wb0_tag,
  input  logic [XLEN-1:0]  wb0_value,
  input  logic             wb0_taken,
  input  logic [XLEN-1:0]  wb0_target,
  input  logic             wb1_valid,
  input  logic [IDX_W-1:0] wb1_tag,
  input  logic [XLEN-1:0]  wb1_value,
  input  logic [IDX_W-1:0] q0_tag,
  input  logic [IDX_W-1:0] q1_tag,
  output logic             q0_ready,
  output logic             q1_ready,
  output logic [XLEN-1:0]  q0_value,
  output logic [XLEN-1:0]  q1_value,
  output logic             commit_valid,
  output logic [REG_W-1:0] commit_rd,
  output logic [XLEN-1:0]  commit_value,
  output logic [IDX_W-1:0] commit_tag,
  output logic             store_commit_valid,
  output logic [IDX_W-1:0] store_commit_tag,
  output logic             flush,
  output logic [XLEN-1:0]  flush_pc
);

  localparam logic [1:0]       T_REG    = 2'd0;
  localparam logic [1:0]       T_BR     = 2'd1;
  localparam logic [1:0]       T_ST     = 2'd2;
  localparam logic [1:0]       T_DONE   = 2'd3;
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);

  logic             busy_q   [DEPTH];
  logic             ready_q  [DEPTH];
  logic [1:0]       type_q   [DEPTH];
  logic [REG_W-1:0] rd_q     [DEPTH];
  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic             pred_q   [DEPTH];
  logic [XLEN-1:0]  value_q  [DEPTH];
  logic             taken_q  [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];

  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [IDX_W:0]   cnt_q;

  logic do_alloc;
  logic do_commit;
  logic head_mispredict;

  assign issue_tag = tail_q;
  assign count     = cnt_q;
  assign full      = (cnt_q == CNT_FULL);

  // Commit decisions use registered state only: a same-cycle writeback waits a cycle.
  assign do_alloc        = issue_valid && !full;
  assign do_commit       = (cnt_q != '0) && ready_q[head_q];
  assign head_mispredict = (type_q[head_q] == T_BR) && (taken_q[head_q] != pred_q[head_q]);

  assign q0_ready = busy_q[q0_tag] && ready_q[q0_tag];
  assign q0_value = value_q[q0_tag];
  assign q1_ready = busy_q[q1_tag] && ready_q[q1_tag];
  assign q1_value = value_q[q1_tag];

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q             <= '0;
      tail_q             <= '0;
      cnt_q              <= '0;
      commit_valid       <= 1'b0;
      commit_rd          <= '0;
      commit_value       <= '0;
      commit_tag         <= '0;
      store_commit_valid <= 1'b0;
      store_commit_tag   <= '0;
      flush              <= 1'b0;
      flush_pc           <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]  <= 1'b0;
        ready_q[i] <= 1'b0;
      end
    end else if (!rdy) begin
      commit_valid       <= 1'b0;
      store_commit_valid <= 1'b0;
      flush              <= 1'b0;
    end else begin
      commit_valid       <= 1'b0;
      store_commit_valid <= 1'b0;
      flush              <= 1'b0;
      // The cycle after a flush is dead: the squashed producers' writebacks must not land.
      if (!flush) begin
        if (wb1_valid && busy_q[wb1_tag]) begin
          ready_q[wb1_tag] <= 1'b1;
          value_q[wb1_tag] <= wb1_value;
        end
        if (wb0_valid && busy_q[wb0_tag]) begin
          ready_q[wb0_tag]  <= 1'b1;
          value_q[wb0_tag]  <= wb0_value;
          taken_q[wb0_tag]  <= wb0_taken;
          target_q[wb0_tag] <= wb0_target;
        end
        if (do_alloc) begin
          busy_q[tail_q]   <= 1'b1;
          ready_q[tail_q]  <= (issue_type == T_DONE);
          type_q[tail_q]   <= issue_type;
          rd_q[tail_q]     <= issue_rd;
          pc_q[tail_q]     <= issue_pc;
          pred_q[tail_q]   <= issue_pred_taken;
          value_q[tail_q]  <= issue_value;
          taken_q[tail_q]  <= 1'b0;
          target_q[tail_q] <= '0;
          tail_q           <= tail_q + PTR_ONE;
        end
        if (do_commit) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + PTR_ONE;
          case (type_q[head_q])
            T_REG, T_DONE: begin
              commit_valid <= 1'b1;
              commit_rd    <= rd_q[head_q];
              commit_value <= value_q[head_q];
              commit_tag   <= head_q;
            end
            T_ST: begin
              store_commit_valid <= 1'b1;
              store_commit_tag   <= head_q;
            end
            default: begin
              if (rd_q[head_q] != '0) begin
                commit_valid <= 1'b1;
                commit_rd    <= rd_q[head_q];
                commit_value <= value_q[head_q];
                commit_tag   <= head_q;
              end
            end
          endcase
        end
        case ({do_alloc, do_commit})
          2'b10:   cnt_q <= cnt_q + CNT_ONE;
          2'b01:   cnt_q <= cnt_q - CNT_ONE;
          default: cnt_q <= cnt_q;
        endcase
        // A mispredicting head squashes everything, overriding this cycle's alloc/writebacks.
        if (do_commit && head_mispredict) begin
          flush    <= 1'b1;
          flush_pc <= taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + PC_STEP;
          head_q   <= '0;
          tail_q   <= '0;
          cnt_q    <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            busy_q[i]  <= 1'b0;
            ready_q[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: queue-based program-order model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rob_param;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  logic             clk;
  logic             rst;
  logic             rdy;
  logic             issue_valid;
  logic [1:0]       issue_type;
  logic [REG_W-1:0] issue_rd;
  logic [XLEN-1:0]  issue_pc;
  logic             issue_pred_taken;
  logic [XLEN-1:0]  issue_value;
  logic [IDX_W-1:0] issue_tag;
  logic             full;
  logic [IDX_W:0]   count;
  logic             wb0_valid;
  logic [IDX_W-1:0] wb0_tag;
  logic [XLEN-1:0]  wb0_value;
  logic             wb0_taken;
  logic [XLEN-1:0]  wb0_target;
  logic             wb1_valid;
  logic [IDX_W-1:0] wb1_tag;
  logic [XLEN-1:0]  wb1_value;
  logic [IDX_W-1:0] q0_tag;
  logic [IDX_W-1:0] q1_tag;
  logic             q0_ready;
  logic             q1_ready;
  logic [XLEN-1:0]  q0_value;
  logic [XLEN-1:0]  q1_value;
  logic             commit_valid;
  logic [REG_W-1:0] commit_rd;
  logic [XLEN-1:0]  commit_value;
  logic [IDX_W-1:0] commit_tag;
  logic             store_commit_valid;
  logic [IDX_W-1:0] store_commit_tag;
  logic             flush;
  logic [XLEN-1:0]  flush_pc;

  rob_param #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken), .issue_value(issue_value),
    .issue_tag(issue_tag), .full(full), .count(count),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_value(wb0_value),
    .wb0_taken(wb0_taken), .wb0_target(wb0_target),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_value(wb1_value),
    .q0_tag(q0_tag), .q1_tag(q1_tag), .q0_ready(q0_ready), .q1_ready(q1_ready),
    .q0_value(q0_value), .q1_value(q1_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .store_commit_valid(store_commit_valid),
    .store_commit_tag(store_commit_tag), .flush(flush), .flush_pc(flush_pc)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Program-order model: one record per in-flight instruction, oldest first.
  typedef struct {
    int               tag;
    logic [1:0]       typ;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  pc;
    logic             pred;
    logic [XLEN-1:0]  value;
    logic             ready;
    logic             taken;
    logic [XLEN-1:0]  target;
  } m_ent_t;

  m_ent_t           m_q[$];
  int               m_next = 0;
  logic             e_cv = 1'b0;
  logic [REG_W-1:0] e_rd = '0;
  logic [XLEN-1:0]  e_val = '0;
  int               e_ctag = 0;
  logic             e_scv = 1'b0;
  int               e_stag = 0;
  logic             e_flush = 1'b0;
  logic [XLEN-1:0]  e_fpc = '0;

  logic [IDX_W+REG_W+XLEN-1:0] commit_log[$];
  int                          commit_cyc[$];

  function automatic int find(input int tag);
    for (int i = 0; i < m_q.size(); i++)
      if (m_q[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic model_step();
    m_ent_t h;
    m_ent_t n;
    bit     ok;
    bit     was_full;
    int     k;
    if (!rst) begin
      m_q.delete();
      m_next = 0;
      e_cv = 0; e_rd = '0; e_val = '0; e_ctag = 0;
      e_scv = 0; e_stag = 0; e_flush = 0; e_fpc = '0;
    end else if (!rdy || e_flush) begin
      e_cv = 0; e_scv = 0; e_flush = 0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      ok = (m_q.size() > 0) && m_q[0].ready;
      if (ok) h = m_q[0];
      e_cv = 0; e_scv = 0; e_flush = 0;
      if (wb1_valid) begin
        k = find(int'(wb1_tag));
        if (k >= 0) begin m_q[k].ready = 1; m_q[k].value = wb1_value; end
      end
      if (wb0_valid) begin
        k = find(int'(wb0_tag));
        if (k >= 0) begin
          m_q[k].ready = 1; m_q[k].value = wb0_value;
          m_q[k].taken = wb0_taken; m_q[k].target = wb0_target;
        end
      end
      if (issue_valid && !was_full) begin
        n.tag = m_next; n.typ = issue_type; n.rd = issue_rd; n.pc = issue_pc;
        n.pred = issue_pred_taken; n.value = issue_value; n.ready = (issue_type == 2'd3);
        n.taken = 1'b0; n.target = '0;
        m_q.push_back(n);
        m_next = (m_next + 1) % DEPTH;
      end
      if (ok) begin
        m_q.delete(0);
        if (h.typ == 2'd2) begin
          e_scv = 1; e_stag = h.tag;
        end else if (h.typ != 2'd1 || h.rd != '0) begin
          e_cv = 1; e_rd = h.rd; e_val = h.value; e_ctag = h.tag;
        end
        if (h.typ == 2'd1 && h.taken != h.pred) begin
          e_flush = 1;
          e_fpc = h.taken ? h.target : h.pc + 32'd4;
          m_q.delete();
          m_next = 0;
        end
      end
    end
  endtask

  // Scoreboard: advance the model on each edge, compare just after it settles.
  always @(posedge clk) begin
    int  k;
    logic exp_r;
    model_step();
    #1;
    chk("count", 64'(count), 64'(m_q.size()));
    chk("full", 64'(full), 64'(m_q.size() == DEPTH));
    chk("issue_tag", 64'(issue_tag), 64'(m_next));
    chk("commit_valid", 64'(commit_valid), 64'(e_cv));
    if (e_cv) begin
      chk("commit_rd", 64'(commit_rd), 64'(e_rd));
      chk("commit_value", 64'(commit_value), 64'(e_val));
      chk("commit_tag", 64'(commit_tag), 64'(e_ctag));
    end
    chk("store_commit_valid", 64'(store_commit_valid), 64'(e_scv));
    if (e_scv) chk("store_commit_tag", 64'(store_commit_tag), 64'(e_stag));
    chk("flush", 64'(flush), 64'(e_flush));
    if (e_flush) chk("flush_pc", 64'(flush_pc), 64'(e_fpc));
    k = find(int'(q0_tag));
    exp_r = (k >= 0) && m_q[k].ready;
    chk("q0_ready", 64'(q0_ready), 64'(exp_r));
    if (exp_r) chk("q0_value", 64'(q0_value), 64'(m_q[k].value));
    k = find(int'(q1_tag));
    exp_r = (k >= 0) && m_q[k].ready;
    chk("q1_ready", 64'(q1_ready), 64'(exp_r));
    if (exp_r) chk("q1_value", 64'(q1_value), 64'(m_q[k].value));
    if (commit_valid) begin
      commit_log.push_back({commit_tag, commit_rd, commit_value});
      commit_cyc.push_back(cyc);
    end
    cyc++;
  end

  // Driver tasks: inputs change on the falling edge only.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [REG_W-1:0] rd,
                          input logic [XLEN-1:0] pc, input logic pred,
                          input logic [XLEN-1:0] val);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd;
    issue_pc = pc; issue_pred_taken = pred; issue_value = val;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_wb0(input logic [IDX_W-1:0] tag, input logic [XLEN-1:0] val,
                        input logic taken, input logic [XLEN-1:0] target);
    wb0_valid = 1'b1; wb0_tag = tag; wb0_value = val;
    wb0_taken = taken; wb0_target = target;
    tick();
    wb0_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int lb;
    rst = 1'b0; rdy = 1'b1;
    issue_valid = 0; issue_type = '0; issue_rd = '0; issue_pc = '0;
    issue_pred_taken = 0; issue_value = '0;
    wb0_valid = 0; wb0_tag = '0; wb0_value = '0; wb0_taken = 0; wb0_target = '0;
    wb1_valid = 0; wb1_tag = '0; wb1_value = '0;
    q0_tag = '0; q1_tag = '0;
    idle(2);

    chk("rst_count", 64'(count), 64'd0);
    chk("rst_issue_tag", 64'(issue_tag), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_commit_rd", 64'(commit_rd), 64'd0);
    chk("rst_commit_value", 64'(commit_value), 64'd0);
    chk("rst_commit_tag", 64'(commit_tag), 64'd0);
    chk("rst_store_valid", 64'(store_commit_valid), 64'd0);
    chk("rst_store_tag", 64'(store_commit_tag), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_flush_pc", 64'(flush_pc), 64'd0);
    rst = 1'b1;

    // Out-of-order writeback, in-order commit
    for (int i = 0; i < 3; i++) begin
      chk("t1_issue_tag", 64'(issue_tag), 64'(i));
      do_issue(2'd0, REG_W'(i + 1), XLEN'(32'h1000 + 4 * i), 1'b0, '0);
    end
    chk("t1_count", 64'(count), 64'd3);
    do_wb0(4'd2, 32'h30, 1'b0, '0);
    do_wb0(4'd0, 32'h10, 1'b0, '0);
    do_wb0(4'd1, 32'h20, 1'b0, '0);
    idle(4);
    chk("t1_ncommits", 64'(commit_log.size()), 64'd3);
    chk("t1_c0", 64'(commit_log[0]), 64'({4'd0, 5'd1, 32'h10}));
    chk("t1_c1", 64'(commit_log[1]), 64'({4'd1, 5'd2, 32'h20}));
    chk("t1_c2", 64'(commit_log[2]), 64'({4'd2, 5'd3, 32'h30}));
    chk("t1_consecutive", 64'(commit_cyc[2] - commit_cyc[0]), 64'd2);

    // Fill to full, refused allocation while full even with a committing head
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_issue(2'd0, REG_W'(i + 1), '0, 1'b0, '0);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_count16", 64'(count), 64'd16);
    do_issue(2'd0, 5'd17, '0, 1'b0, '0);
    chk("t2_17th_ignored", 64'(count), 64'd16);
    do_wb0(4'd0, 32'h55, 1'b0, '0);
    issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd20; issue_value = '0;
    tick();
    chk("t2_refused_count", 64'(count), 64'd15);
    chk("t2_refused_tag", 64'(issue_tag), 64'd0);
    tick();
    issue_valid = 1'b0;
    chk("t2_accept_count", 64'(count), 64'd16);
    chk("t2_accept_tag", 64'(issue_tag), 64'd1);
    for (int t = 0; t < DEPTH; t++) do_wb0(IDX_W'(t), XLEN'(32'h100 + t), 1'b0, '0);
    idle(4);
    chk("t2_drained", 64'(count), 64'd0);
    chk("t2_last_commit", 64'(commit_log[commit_log.size() - 1]), 64'({4'd0, 5'd20, 32'h100}));

    // Mispredict (not-taken predicted, taken actual) with younger ready entries
    do_issue(2'd1, 5'd0, 32'h100, 1'b0, '0);
    do_issue(2'd0, 5'd4, 32'h104, 1'b0, '0);
    do_issue(2'd0, 5'd5, 32'h108, 1'b0, '0);
    do_issue(2'd0, 5'd6, 32'h10C, 1'b0, '0);
    do_wb0(4'd2, 32'h44, 1'b0, '0);
    do_wb0(4'd3, 32'h55, 1'b0, '0);
    do_wb0(4'd4, 32'h66, 1'b0, '0);
    lb = commit_log.size();
    do_wb0(4'd1, 32'h0, 1'b1, 32'h200);
    tick();
    chk("t3_flush", 64'(flush), 64'd1);
    chk("t3_flush_pc", 64'(flush_pc), 64'h200);
    chk("t3_count", 64'(count), 64'd0);
    chk("t3_issue_tag", 64'(issue_tag), 64'd0);
    chk("t3_no_link", 64'(commit_valid), 64'd0);
    issue_valid = 1'b1; issue_type = 2'd3; issue_rd = 5'd9; issue_value = 32'h99;
    tick();
    chk("t3_flush_cycle_ignored", 64'(count), 64'd0);
    chk("t3_flush_clear", 64'(flush), 64'd0);
    tick();
    issue_valid = 1'b0;
    chk("t3_resume_count", 64'(count), 64'd1);
    chk("t3_resume_tag", 64'(issue_tag), 64'd1);
    tick();
    chk("t3_done_commit", 64'(commit_valid), 64'd1);
    chk("t3_done_rd", 64'(commit_rd), 64'd9);
    chk("t3_done_value", 64'(commit_value), 64'h99);
    chk("t3_done_tag", 64'(commit_tag), 64'd0);
    chk("t3_younger_squashed", 64'(commit_log.size()), 64'(lb + 1));

    // Predicted taken, actually not taken at top of address space
    do_issue(2'd1, 5'd0, 32'hFFFF_FFFC, 1'b1, '0);
    do_wb0(4'd1, 32'h0, 1'b0, 32'h1234);
    tick();
    chk("t4_flush", 64'(flush), 64'd1);
    chk("t4_flush_pc_wrap", 64'(flush_pc), 64'h0);
    tick();
    chk("t4_flush_pulse", 64'(flush), 64'd0);
    do_issue(2'd1, 5'd1, 32'h300, 1'b1, '0);
    do_wb0(4'd0, 32'h304, 1'b1, 32'h400);
    tick();
    chk("t4_ok_no_flush", 64'(flush), 64'd0);
    chk("t4_link_valid", 64'(commit_valid), 64'd1);
    chk("t4_link_rd", 64'(commit_rd), 64'd1);
    chk("t4_link_value", 64'(commit_value), 64'h304);
    do_issue(2'd1, 5'd0, 32'h400, 1'b0, '0);
    do_wb0(4'd1, 32'h0, 1'b0, 32'h800);
    tick();
    chk("t4_nolink_valid", 64'(commit_valid), 64'd0);
    chk("t4_nolink_flush", 64'(flush), 64'd0);
    chk("t4_nolink_count", 64'(count), 64'd0);

    // Store commit and dual writeback priority
    do_reset();
    for (int i = 0; i < 5; i++) do_issue(2'd3, 5'd11, '0, 1'b0, XLEN'(i));
    do_issue(2'd2, 5'd0, 32'h500, 1'b0, '0);
    do_issue(2'd0, 5'd8, 32'h504, 1'b0, '0);
    q0_tag = 4'd6; q1_tag = 4'd5;
    wb0_valid = 1'b1; wb0_tag = 4'd6; wb0_value = 32'hA; wb0_taken = 1'b0; wb0_target = '0;
    wb1_valid = 1'b1; wb1_tag = 4'd6; wb1_value = 32'hB;
    tick();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    chk("t5_q0_ready", 64'(q0_ready), 64'd1);
    chk("t5_q0_value", 64'(q0_value), 64'hA);
    chk("t5_q1_store_pending", 64'(q1_ready), 64'd0);
    wb1_valid = 1'b1; wb1_tag = 4'd5; wb1_value = 32'hDEAD;
    tick();
    wb1_valid = 1'b0;
    tick();
    chk("t5_store_valid", 64'(store_commit_valid), 64'd1);
    chk("t5_store_tag", 64'(store_commit_tag), 64'd5);
    chk("t5_store_no_commit", 64'(commit_valid), 64'd0);
    tick();
    chk("t5_after_store", 64'(commit_log[commit_log.size() - 1]), 64'({4'd6, 5'd8, 32'hA}));

    // Stall with a ready head
    do_issue(2'd3, 5'd10, '0, 1'b0, 32'h77);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_stall_count", 64'(count), 64'd1);
      chk("t6_stall_commit", 64'(commit_valid), 64'd0);
    end
    rdy = 1'b1;
    tick();
    chk("t6_resume_commit", 64'(commit_valid), 64'd1);
    chk("t6_resume_rd", 64'(commit_rd), 64'd10);
    chk("t6_resume_value", 64'(commit_value), 64'h77);
    chk("t6_resume_count", 64'(count), 64'd0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) do_issue(2'd0, REG_W'(12 + i), '0, 1'b0, '0);
    do_wb0(IDX_W'(8), 32'h12, 1'b0, '0);
    do_reset();
    chk("t7_count", 64'(count), 64'd0);
    chk("t7_issue_tag", 64'(issue_tag), 64'd0);
    chk("t7_commit_valid", 64'(commit_valid), 64'd0);
    chk("t7_commit_rd", 64'(commit_rd), 64'd0);
    chk("t7_commit_value", 64'(commit_value), 64'd0);
    chk("t7_store_tag", 64'(store_commit_tag), 64'd0);
    chk("t7_flush_pc", 64'(flush_pc), 64'd0);
    chk("t7_q0_ready", 64'(q0_ready), 64'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
